// File: rtl/alu_irq_pipe.sv
// alu_irq_pipe: 2-stage valid/ready bitwise ALU with a programmable match-table interrupt
module alu_irq_pipe #(
  parameter int WIDTH     = 8,
  parameter int IRQ_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 global_enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 enable_a,
  input  logic                 enable_b,
  input  logic [1:0]           op_a,
  input  logic [1:0]           op_b,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic [2:0]           out_op,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [WIDTH-1:0]     cfg_wdata,
  output logic [WIDTH-1:0]     cfg_rdata,
  input  logic                 irq_clear,
  output logic                 irq,
  output logic [2:0]           irq_src,
  output logic [IRQ_CNT_W-1:0] irq_cnt
);
  logic                 s1_valid, s2_valid, advance1, advance2, load2, ev;
  logic [WIDTH-1:0]     s1_a, s1_b, res;
  logic [2:0]           s1_k;
  logic [WIDTH-1:0]     match [8];
  logic [7:0]           irq_mask;
  assign advance2  = global_enable && (!s2_valid || out_ready);
  assign advance1  = global_enable && (!s1_valid || advance2);
  assign in_ready  = advance1;
  assign out_valid = s2_valid;
  assign load2     = advance2 && s1_valid;
  assign ev        = load2 && irq_mask[s1_k] && res == match[s1_k];
  assign cfg_rdata = cfg_addr[3] ? (cfg_addr[2:0] == 3'd0 ? WIDTH'(irq_mask) : '0) : match[cfg_addr[2:0]];
  always_comb begin
    res = '0;
    case (s1_k)
      3'd0, 3'd5: res = s1_a & s1_b;
      3'd1:       res = ~(s1_a & s1_b);
      3'd2, 3'd7: res = s1_a | s1_b;
      3'd3:       res = s1_a ^ s1_b;
      3'd4:       res = ~(s1_a ^ s1_b);
      default:    res = ~(s1_a | s1_b);
    endcase
  end
  // Beats with no op group selected are swallowed at S1 entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_k     <= '0;
      s2_valid <= 1'b0;
      out      <= '0;
      out_op   <= '0;
    end else begin
      if (advance1) begin
        s1_valid <= in_valid && (enable_a || enable_b);
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_k     <= enable_a ? {1'b0, op_a} : {1'b1, op_b};
      end
      if (advance2) s2_valid <= s1_valid;
      if (load2) begin
        out    <= res;
        out_op <= s1_k;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) match[i] <= '1;
      irq_mask <= '0;
    end else if (cfg_we && !cfg_addr[3]) begin
      match[cfg_addr[2:0]] <= cfg_wdata;
    end else if (cfg_we && cfg_addr == 4'd8) begin
      irq_mask <= cfg_wdata[7:0];
    end
  end
  // A same-cycle event overrides irq_clear and restarts the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq     <= 1'b0;
      irq_src <= '0;
      irq_cnt <= '0;
    end else if (ev) begin
      irq <= 1'b1;
      if (!irq || irq_clear) irq_src <= s1_k;
      irq_cnt <= irq_clear ? IRQ_CNT_W'(1) : (&irq_cnt ? irq_cnt : irq_cnt + 1'b1);
    end else if (irq_clear) begin
      irq     <= 1'b0;
      irq_src <= '0;
      irq_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_alu_irq_pipe.sv
// tb_alu_irq_pipe: directed vector table plus hand-written pipeline and irq sequences
module tb_alu_irq_pipe;
  logic       clk = 1'b0, rst_n = 1'b0, global_enable = 1'b1;
  logic       in_valid = 1'b0, in_ready, enable_a = 1'b0, enable_b = 1'b0;
  logic [1:0] op_a = '0, op_b = '0;
  logic [7:0] in_a = '0, in_b = '0, out, cfg_wdata = '0, cfg_rdata;
  logic       out_valid, out_ready = 1'b1, cfg_we = 1'b0, irq_clear = 1'b0, irq;
  logic [3:0] cfg_addr = '0;
  logic [2:0] out_op, irq_src;
  logic [1:0] irq_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    logic       ea, eb;
    logic [1:0] oa, ob;
    logic [7:0] a, b, eo;
    logic [2:0] ek;
    logic       ev;
  } vec_t;
  vec_t vecs [10];
  alu_irq_pipe #(.WIDTH(8), .IRQ_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .global_enable(global_enable),
    .in_valid(in_valid), .in_ready(in_ready), .enable_a(enable_a), .enable_b(enable_b),
    .op_a(op_a), .op_b(op_b), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_op(out_op),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_clear(irq_clear), .irq(irq), .irq_src(irq_src), .irq_cnt(irq_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic beat(input logic ea, eb, input logic [1:0] oa, ob, input logic [7:0] a, b);
    in_valid = 1'b1;
    enable_a = ea;
    enable_b = eb;
    op_a = oa;
    op_b = ob;
    in_a = a;
    in_b = b;
  endtask
  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    tick;
    cfg_we = 1'b0;
  endtask
  task automatic cfg_read(input string name, input logic [3:0] addr, input logic [7:0] exp);
    cfg_addr = addr;
    #1;
    check(name, cfg_rdata, exp);
  endtask
  task automatic irq_state(input string name, input logic ei, input logic [2:0] es, input logic [1:0] ec);
    check({name, "_irq"}, irq, ei);
    check({name, "_src"}, irq_src, es);
    check({name, "_cnt"}, irq_cnt, ec);
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd0, 2'd0, 8'hF0, 8'h3C, 8'h30, 3'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 2'd0, 8'hF0, 8'h3C, 8'hCF, 3'd1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 2'd0, 8'hA5, 8'h0F, 8'hAF, 3'd2, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 2'd0, 8'hA5, 8'h0F, 8'hAA, 3'd3, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'd0, 2'd0, 8'hA5, 8'h0F, 8'h55, 3'd4, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 2'd1, 8'hF0, 8'h3C, 8'h30, 3'd5, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 2'd2, 8'hA5, 8'h0F, 8'h50, 3'd6, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 2'd0, 2'd3, 8'hF0, 8'h3C, 8'hFC, 3'd7, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 2'd3, 2'd2, 8'hF0, 8'h3C, 8'hCC, 3'd3, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 2'd1, 2'd1, 8'hF0, 8'h3C, 8'h00, 3'd0, 1'b0};
    tick;
    tick;
    #2 rst_n = 1'b1;
    tick;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    irq_state("rst", 1'b0, 3'd0, 2'd0);
    check("rst_out", out, 8'h00);
    cfg_read("rst_match0", 4'd0, 8'hFF);
    cfg_read("rst_mask", 4'd8, 8'h00);
    for (int i = 0; i < 10; i++) begin
      beat(vecs[i].ea, vecs[i].eb, vecs[i].oa, vecs[i].ob, vecs[i].a, vecs[i].b);
      tick;
      in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", i), out_valid, 1'b0);
      tick;
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_out", i), out, vecs[i].eo);
        check($sformatf("vec%0d_op", i), out_op, vecs[i].ek);
      end
      tick;
    end
    for (int t = 0; t < 6; t++) begin
      if (t < 4) beat(1'b1, 1'b0, 2'd0, 2'd0, 8'hF0 | 8'(t), 8'h0F);
      else in_valid = 1'b0;
      tick;
      if (t >= 1 && t <= 4) begin
        check($sformatf("stream%0d_valid", t), out_valid, 1'b1);
        check($sformatf("stream%0d_out", t), out, 8'(t - 1));
      end
    end
    check("stream_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    beat(1'b1, 1'b0, 2'd3, 2'd0, 8'h01, 8'h10);
    tick;
    check("bp_ready0", in_ready, 1'b1);
    beat(1'b1, 1'b0, 2'd3, 2'd0, 8'h02, 8'h10);
    tick;
    beat(1'b1, 1'b0, 2'd3, 2'd0, 8'h03, 8'h10);
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("bp%0d_in_ready", s), in_ready, 1'b0);
      check($sformatf("bp%0d_valid", s), out_valid, 1'b1);
      check($sformatf("bp%0d_out", s), out, 8'h11);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    check("bp_out1", out, 8'h12);
    tick;
    check("bp_out2", out, 8'h13);
    check("bp_out2_valid", out_valid, 1'b1);
    tick;
    check("bp_drained", out_valid, 1'b0);
    cfg_write(4'd3, 8'h83);
    cfg_write(4'd8, 8'h08);
    cfg_read("match3_rd", 4'd3, 8'h83);
    beat(1'b1, 1'b0, 2'd3, 2'd0, 8'h80, 8'h03);
    tick;
    in_valid = 1'b0;
    tick;
    irq_state("ev1", 1'b1, 3'd3, 2'd1);
    tick;
    cfg_write(4'd6, 8'h00);
    cfg_write(4'd8, 8'h48);
    beat(1'b0, 1'b1, 2'd0, 2'd2, 8'h0F, 8'hF0);
    tick;
    in_valid = 1'b0;
    tick;
    irq_state("ev2", 1'b1, 3'd3, 2'd2);
    tick;
    beat(1'b0, 1'b1, 2'd0, 2'd2, 8'h0F, 8'hF0);
    tick;
    in_valid = 1'b0;
    irq_clear = 1'b1;
    tick;
    irq_clear = 1'b0;
    irq_state("clr_ev", 1'b1, 3'd6, 2'd1);
    irq_clear = 1'b1;
    tick;
    irq_clear = 1'b0;
    irq_state("clr", 1'b0, 3'd0, 2'd0);
    beat(1'b1, 1'b0, 2'd3, 2'd0, 8'h80, 8'h03);
    tick;
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 4'd3;
    cfg_wdata = 8'h00;
    tick;
    cfg_we = 1'b0;
    irq_state("old_match", 1'b1, 3'd3, 2'd1);
    cfg_read("match3_new", 4'd3, 8'h00);
    irq_clear = 1'b1;
    tick;
    irq_clear = 1'b0;
    cfg_write(4'd3, 8'h83);
    cfg_write(4'd9, 8'hAA);
    cfg_read("reserved_rd", 4'd9, 8'h00);
    cfg_read("mask_rd", 4'd8, 8'h48);
    beat(1'b1, 1'b0, 2'd0, 2'd0, 8'h0F, 8'h3C);
    tick;
    beat(1'b1, 1'b0, 2'd0, 2'd0, 8'hF0, 8'h3C);
    tick;
    global_enable = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_wdata = 8'h55;
    #1;
    check("frz_in_ready", in_ready, 1'b0);
    tick;
    cfg_we = 1'b0;
    tick;
    check("frz_valid", out_valid, 1'b1);
    check("frz_out", out, 8'h0C);
    cfg_read("frz_cfg", 4'd0, 8'h55);
    global_enable = 1'b1;
    in_valid = 1'b0;
    tick;
    check("unfrz_out", out, 8'h30);
    check("unfrz_valid", out_valid, 1'b1);
    tick;
    check("unfrz_drained", out_valid, 1'b0);
    for (int n = 0; n < 5; n++) begin
      beat(1'b1, 1'b0, 2'd3, 2'd0, 8'h80, 8'h03);
      tick;
    end
    in_valid = 1'b0;
    tick;
    tick;
    irq_state("sat", 1'b1, 3'd3, 2'd3);
    beat(1'b1, 1'b0, 2'd0, 2'd0, 8'hFF, 8'hFF);
    tick;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_irq", irq, 1'b0);
    cfg_read("mid_rst_mask", 4'd8, 8'h00);
    tick;
    rst_n = 1'b1;
    tick;
    check("post_rst_valid", out_valid, 1'b0);
    cfg_read("post_rst_match0", 4'd0, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
